// File: rtl/gsim_residual_check_if.sv
// Bundles the GSIM snoop inputs and the residual-check result outputs.
// Latency: none; wires only.
// Backpressure: none; the checker is a passive observer and never stalls either stream.
interface gsim_residual_check_if;
  logic               in_en;
  logic signed [15:0] b_in;
  logic               out_valid;
  logic signed [31:0] x_out;
  logic               res_valid;
  logic [3:0]         res_idx;
  logic signed [39:0] res_out;
  logic               done;
  logic               pass;
  logic [39:0]        max_abs;

  // Source side: drives the b stream and the solver output, observes results.
  modport master (
    output in_en, b_in, out_valid, x_out,
    input  res_valid, res_idx, res_out, done, pass, max_abs
  );

  // Checker side.
  modport slave (
    input  in_en, b_in, out_valid, x_out,
    output res_valid, res_idx, res_out, done, pass, max_abs
  );
endinterface

// File: rtl/gsim_residual_check.sv
// Recomputes r = M*x - b for the 16x16 banded GSIM matrix and reports per-row residuals, max |r| and pass.
// Latency: row 0 two edges after both vectors are complete, one row per cycle, done one cycle after row 15.
// Backpressure: none; captures beyond 16 per vector and any captures while computing are dropped.
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter int unsigned TOL = 16
) (
  input logic                  clk,
  input logic                  reset,
  gsim_residual_check_if.slave bus
);

  localparam logic [1:0]  COLLECT = 2'd0;
  localparam logic [1:0]  COMPUTE = 2'd1;
  localparam logic [1:0]  FINISH  = 2'd2;
  localparam logic [4:0]  FULL    = 5'(N);
  localparam logic [39:0] TOL_W   = 40'(TOL);

  logic [1:0]         state;
  logic [4:0]         b_cnt;
  logic [4:0]         x_cnt;
  logic [3:0]         row;
  logic signed [15:0] bbuf [N];
  logic signed [31:0] xbuf [N];
  logic signed [39:0] win  [7];
  logic signed [39:0] b_term;
  logic signed [39:0] sum_1;
  logic signed [39:0] sum_2;
  logic signed [39:0] sum_3;
  logic signed [39:0] r_row;
  logic [39:0]        r_abs;
  logic               b_take;
  logic               x_take;

  assign b_take = (state == COLLECT) && bus.in_en     && (b_cnt < FULL);
  assign x_take = (state == COLLECT) && bus.out_valid && (x_cnt < FULL);

  // Vector buffers hold their contents across reset; a run only uses fresh captures.
  always_ff @(posedge clk) begin
    if (!reset && b_take) bbuf[b_cnt[3:0]] <= bus.b_in;
    if (!reset && x_take) xbuf[x_cnt[3:0]] <= bus.x_out;
  end

  // Gather the 7-wide band around the current row; columns outside 0..15 contribute zero.
  always_comb begin
    logic [5:0] j;
    j = '0;
    for (int k = 0; k < 7; k++) begin
      // Negative columns wrap to 61..63, so a single upper-bound test covers both edges.
      j = {2'b00, row} + 6'(k) - 6'd3;
      if (j <= 6'd15) win[k] = {{8{xbuf[j[3:0]][31]}}, xbuf[j[3:0]]};
      else            win[k] = '0;
    end
  end

  // Residual of the current row using shift-add coefficients 20, -13, 6, -1.
  always_comb begin
    b_term = {{8{bbuf[row][15]}}, bbuf[row], 16'h0000};
    sum_1  = win[2] + win[4];
    sum_2  = win[1] + win[5];
    sum_3  = win[0] + win[6];
    r_row  = (win[3] <<< 4) + (win[3] <<< 2)
           - ((sum_1 <<< 3) + (sum_1 <<< 2) + sum_1)
           + ((sum_2 <<< 2) + (sum_2 <<< 1))
           - sum_3
           - b_term;
    r_abs  = r_row[39] ? $unsigned(-r_row) : $unsigned(r_row);
  end

  // Sequencer: collect both vectors, stream 16 residual rows, then report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= COLLECT;
      b_cnt         <= '0;
      x_cnt         <= '0;
      row           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_idx   <= '0;
      bus.res_out   <= '0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.max_abs   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        COLLECT: begin
          if ((b_cnt == FULL) && (x_cnt == FULL)) begin
            state       <= COMPUTE;
            row         <= '0;
            bus.pass    <= 1'b0;
            bus.max_abs <= '0;
          end else begin
            if (b_take) b_cnt <= b_cnt + 5'd1;
            if (x_take) x_cnt <= x_cnt + 5'd1;
          end
        end
        COMPUTE: begin
          bus.res_valid <= 1'b1;
          bus.res_idx   <= row;
          bus.res_out   <= r_row;
          if (r_abs > bus.max_abs) bus.max_abs <= r_abs;
          row <= row + 4'd1;
          if (row == 4'd15) state <= FINISH;
        end
        FINISH: begin
          bus.res_valid <= 1'b0;
          bus.done      <= 1'b1;
          bus.pass      <= (bus.max_abs <= TOL_W);
          b_cnt         <= '0;
          x_cnt         <= '0;
          state         <= COLLECT;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule
